// File: rtl/riscv_pkg.sv
// Shared RV64 core definitions: opcodes, ALUOp encodings, default widths and
// the decoded control bundle carried down the pipeline.
package riscv_pkg;

  localparam int DEF_XLEN   = 64;
  localparam int DEF_REG_AW = 5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_BUBBLE  = 2'd3
  } stage_act_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX boundary bundle: decoded fields in, registered EX fields and the
// fetch stall request out.
interface id_ex_stage_if #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
);
  logic              id_valid_i;
  logic              id_RegWrite_i, id_MemRead_i, id_MemWrite_i;
  logic              id_MemtoReg_i, id_ALUSrc_i, id_Branch_i;
  logic [1:0]        id_ALUOp_i;
  logic [XLEN-1:0]   id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0]        id_funct3_i;
  logic              id_funct7b5_i;
  logic              flush_i;
  logic              hold_i;

  logic              ex_valid_o;
  logic              ex_RegWrite_o, ex_MemRead_o, ex_MemWrite_o;
  logic              ex_MemtoReg_o, ex_ALUSrc_o, ex_Branch_o;
  logic [1:0]        ex_ALUOp_o;
  logic [XLEN-1:0]   ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [REG_AW-1:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [2:0]        ex_funct3_o;
  logic              ex_funct7b5_o;
  logic              stall_o;

  modport master (
    output id_valid_i, id_RegWrite_i, id_MemRead_i, id_MemWrite_i,
           id_MemtoReg_i, id_ALUSrc_i, id_Branch_i, id_ALUOp_i,
           id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_funct7b5_i,
           flush_i, hold_i,
    input  ex_valid_o, ex_RegWrite_o, ex_MemRead_o, ex_MemWrite_o,
           ex_MemtoReg_o, ex_ALUSrc_o, ex_Branch_o, ex_ALUOp_o,
           ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o,
           stall_o
  );

  modport slave (
    input  id_valid_i, id_RegWrite_i, id_MemRead_i, id_MemWrite_i,
           id_MemtoReg_i, id_ALUSrc_i, id_Branch_i, id_ALUOp_i,
           id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_funct7b5_i,
           flush_i, hold_i,
    output ex_valid_o, ex_RegWrite_o, ex_MemRead_o, ex_MemWrite_o,
           ex_MemtoReg_o, ex_ALUSrc_o, ex_Branch_o, ex_ALUOp_o,
           ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o,
           stall_o
  );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use check: does the ID instruction read the register a
// valid load in EX is about to produce?
module load_use_detect
  import riscv_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_branch,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);
  logic uses_rs1, uses_rs2, ex_is_load;

  assign uses_rs1   = id_reg_write | id_mem_write | id_branch;
  assign uses_rs2   = (~id_alu_src & (id_reg_write | id_branch)) | id_mem_write;
  // x0 is hardwired zero, so a load targeting it never produces a dependency
  assign ex_is_load = ex_valid & ex_mem_read & (ex_rd != '0);
  assign load_use   = ex_is_load & id_valid &
                      ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, redirect flush and
// downstream hold. Optional hazard counters under HAZARD_PERF_EN.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_stage_if.slave bus,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);
  ctrl_t             id_ctrl, ex_ctrl, ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [XLEN-1:0]   pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  logic [REG_AW-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [2:0]        funct3_d, funct3_q;
  logic              funct7b5_d, funct7b5_q;
  logic              load_use;
  stage_act_e        act;

  assign id_ctrl = {bus.id_RegWrite_i, bus.id_MemRead_i, bus.id_MemWrite_i,
                    bus.id_MemtoReg_i, bus.id_ALUSrc_i, bus.id_Branch_i, bus.id_ALUOp_i};

  // Controls are stored raw and gated by valid, so a non-valid slot is inert
  assign ex_ctrl = valid_q ? ctrl_q : CTRL_NOP;

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .id_valid     (bus.id_valid_i),
    .id_reg_write (bus.id_RegWrite_i),
    .id_mem_write (bus.id_MemWrite_i),
    .id_alu_src   (bus.id_ALUSrc_i),
    .id_branch    (bus.id_Branch_i),
    .id_rs1       (bus.id_rs1_i),
    .id_rs2       (bus.id_rs2_i),
    .ex_valid     (valid_q),
    .ex_mem_read  (ex_ctrl.mem_read),
    .ex_rd        (rd_q),
    .load_use     (load_use)
  );

  always_comb begin
    act = ACT_ADVANCE;
    if (bus.hold_i)      act = ACT_HOLD;
    else if (bus.flush_i) act = ACT_FLUSH;
    else if (load_use)   act = ACT_BUBBLE;
  end

  // Flush wins over bubble: fetch must follow the redirect, not re-present ID
  assign bus.stall_o = rst_n & ((act == ACT_HOLD) | (act == ACT_BUBBLE));

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
      end
      ACT_ADVANCE: begin
        valid_d    = bus.id_valid_i;
        ctrl_d     = id_ctrl;
        pc_d       = bus.id_pc_i;
        rs1_data_d = bus.id_rs1_data_i;
        rs2_data_d = bus.id_rs2_data_i;
        imm_d      = bus.id_imm_i;
        rs1_d      = bus.id_rs1_i;
        rs2_d      = bus.id_rs2_i;
        rd_d       = bus.id_rd_i;
        funct3_d   = bus.id_funct3_i;
        funct7b5_d = bus.id_funct7b5_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
    end
  end

  assign bus.ex_valid_o    = valid_q;
  assign bus.ex_RegWrite_o = ex_ctrl.reg_write;
  assign bus.ex_MemRead_o  = ex_ctrl.mem_read;
  assign bus.ex_MemWrite_o = ex_ctrl.mem_write;
  assign bus.ex_MemtoReg_o = ex_ctrl.mem_to_reg;
  assign bus.ex_ALUSrc_o   = ex_ctrl.alu_src;
  assign bus.ex_Branch_o   = ex_ctrl.branch;
  assign bus.ex_ALUOp_o    = ex_ctrl.alu_op;
  assign bus.ex_pc_o       = pc_q;
  assign bus.ex_rs1_data_o = rs1_data_q;
  assign bus.ex_rs2_data_o = rs2_data_q;
  assign bus.ex_imm_o      = imm_q;
  assign bus.ex_rs1_o      = rs1_q;
  assign bus.ex_rs2_o      = rs2_q;
  assign bus.ex_rd_o       = rd_q;
  assign bus.ex_funct3_o   = funct3_q;
  assign bus.ex_funct7b5_o = funct7b5_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (act == ACT_BUBBLE) stall_cnt_d = sat_inc(stall_cnt_q);
    if (act == ACT_FLUSH)  flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID→EX pipeline register of the RV64 5-stage core, directly downstream of the decode control unit.
- Latches the decoded control bundle and operands, and owns load-use hazard detection.
- Inserts bubbles on load-use hazards and flushes on taken-branch redirect.
- Drives the stall request back to the PC and IF/ID registers.

Parameters:
- XLEN, 64, datapath width (ld/sd are doubleword).
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_RegWrite_i, id_MemRead_i, id_MemWrite_i, id_MemtoReg_i, id_ALUSrc_i, id_Branch_i  in  1 each  decoded controls
- id_ALUOp_i  in  2  decoded ALUOp (00 add, 01 branch-compare, 10 R-type funct)
- id_pc_i  in  XLEN  instruction PC
- id_rs1_data_i, id_rs2_data_i, id_imm_i  in  XLEN  operands, sign-extended immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register indices
- id_funct3_i  in  3  funct3
- id_funct7b5_i  in  1  instr[30]
- flush_i  in  1  taken branch resolved downstream; kill ID instruction
- hold_i  in  1  downstream (memory) back-pressure; freeze stage
- ex_* outputs  out  same widths as id_* counterparts  registered copies, plus ex_valid_o (1)
- stall_o  out  1  combinational; PC and IF/ID must not advance
- stall_cnt_o, flush_cnt_o  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0, ex_valid_o 0, counters 0; remains so until first rising clk after release.
- Latency: 1 cycle ID→EX when no hazard.
- uses_rs1 = RegWrite | MemWrite | Branch.
- uses_rs2 = (~ALUSrc & (RegWrite | Branch)) | MemWrite.
- load_use = ex_valid_o & ex_MemRead_o & (ex_rd_o != 0) & id_valid_i & ((uses_rs1 & id_rs1_i==ex_rd_o) | (uses_rs2 & id_rs2_i==ex_rd_o)).
- Per-cycle action, priority order:
  - HOLD (hold_i=1): every ex_* register retains its value; stall_o=1; flush_i and load_use ignored this cycle.
  - FLUSH (flush_i=1): load bubble; stall_o=0 (fetch must take the redirect target).
  - BUBBLE (load_use=1): load bubble; stall_o=1 so the same ID instruction is re-presented next cycle.
  - ADVANCE: capture all id_* fields; ex_valid_o <= id_valid_i; stall_o=0.
- Bubble: ex_valid_o and all seven control bits/ALUOp cleared to 0; data and index fields hold their previous values (don't care, but must not toggle).
- id_valid_i=0 on ADVANCE: controls are captured as-is but gated to 0 on the outputs; a non-valid EX slot never writes registers or memory and never triggers load_use.
- rd=x0 never causes a stall.
- Back-to-back loads: a second load consuming the first load's rd stalls exactly 1 cycle.
- Reset asserted mid-stall: stall_o drops combinationally once ex_valid_o clears.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: stall_cnt_o increments on every BUBBLE cycle; flush_cnt_o increments on every FLUSH cycle. Counters are 32-bit, saturate at 0xFFFF_FFFF, do not count during HOLD, and reset to 0.
- Undefined: no counter flops; both ports tied to 0. Port list is unchanged.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (OP_R 0110011, OP_I 0010011, OP_LD 0000011, OP_SD 0100011, OP_BEQ 1100011).
  - ALUOp encodings.
  - XLEN/REG_AW defaults.
  - ctrl bundle typedef {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0]} = 8 bits, with CTRL_NOP = 0.
- One sub-module, load_use_detect: purely combinational; computes uses_rs1/uses_rs2 and load_use.

Test Plan:
- Reset: rst_n low mid-cycle with random inputs → all ex_* = 0 and stall_o = 0 immediately, with no clock required.
- Advance: add x3,x1,x2 (RegWrite=1, ALUOp=10, rd=3) → next cycle ex_rd_o=3, ex_ALUOp_o=10, ex_valid_o=1, stall_o=0.
- Load-use: EX holds ld x5 (MemRead=1, rd=5); ID presents add x6,x5,x7 → stall_o=1, next cycle ex_valid_o=0 with controls 0; following cycle the add captures and stall_o=0.
- x0 and sd cases: ld x0 followed by use of x0 → no stall. ld x5 then sd x5,0(x8) (uses rs2=5) → 1-cycle stall.
- Flush vs stall: flush_i=1 together with a load_use condition → stall_o=0 and a bubble is loaded; with HAZARD_PERF_EN, flush_cnt_o +1 and stall_cnt_o unchanged.
- Hold: hold_i=1 for 3 cycles with changing id_* inputs → ex_* stay constant and stall_o=1 throughout; stage resumes correctly on release.
